// File: rtl/ttl_bist_pkg.sv
// Shared types and helpers for the TTL_7400 built-in self-test controller.
package ttl_bist_pkg;

    localparam int unsigned NUM_GATES = 4;
    localparam int unsigned NUM_STEPS = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_REPORT = 2'd3
    } bist_state_t;

    // Pattern code u = (v + k) mod 4 for gate k at step v, returned as {B, A}.
    // Rotating by gate index gives neighbouring gates different inputs.
    function automatic logic [1:0] vec(input logic [1:0] v, input logic [1:0] k);
        return v + k;
    endfunction

    function automatic logic nand_exp(input logic a, input logic b);
        return ~(a & b);
    endfunction

endpackage

// File: rtl/bist_settle_timer.sv
// 8-bit loadable down-counter that times the settle window after each vector.
module bist_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       expire
);

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - 8'd1;
        end
    end

    assign expire = (value == 8'd1);

endmodule

// File: rtl/ttl_7400_bist.sv
// Self-test controller for one quad 2-input NAND package: drives four
// rotated vectors, samples Y after a settle window and records failures.
module ttl_7400_bist
    import ttl_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       Y1,
    input  logic       Y2,
    input  logic       Y3,
    input  logic       Y4,
    output logic       A1,
    output logic       B1,
    output logic       A2,
    output logic       B2,
    output logic       A3,
    output logic       B3,
    output logic       A4,
    output logic       B4,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [3:0] FAIL_MAP,
    output logic [1:0] FAIL_STEP
);

    localparam logic [7:0] SETTLE_LOAD = SETTLE_CYCLES[7:0];
    localparam logic [1:0] LAST_STEP   = 2'(NUM_STEPS - 1);

    bist_state_t state;
    logic [1:0]  step;
    logic [3:0]  a_reg, b_reg;
    logic [3:0]  a_nxt, b_nxt;
    logic [3:0]  exp_y, mismatch;
    logic [1:0]  drive_step;
    logic [7:0]  cnt_value;
    logic        cnt_expire;
    logic        cnt_load;
    logic        start_run;
    logic        last_step;

    assign start_run = (state == ST_IDLE) && START;
    assign last_step = (step == LAST_STEP);
    assign cnt_load  = start_run || ((state == ST_SAMPLE) && !last_step);

    bist_settle_timer u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load),
        .dec      (state == ST_SETTLE),
        .load_val (SETTLE_LOAD),
        .value    (cnt_value),
        .expire   (cnt_expire)
    );

    // Expected Y for the current step and next-step drive vectors.
    always_comb begin
        logic [1:0] u_cur;
        logic [1:0] u_nxt;
        exp_y      = '0;
        a_nxt      = '0;
        b_nxt      = '0;
        drive_step = (state == ST_IDLE) ? 2'd0 : step + 2'd1;
        for (int unsigned k = 0; k < NUM_GATES; k++) begin
            u_cur    = vec(step, 2'(k));
            u_nxt    = vec(drive_step, 2'(k));
            exp_y[k] = nand_exp(u_cur[0], u_cur[1]);
            a_nxt[k] = u_nxt[0];
            b_nxt[k] = u_nxt[1];
        end
        mismatch = exp_y ^ {Y4, Y3, Y2, Y1};
    end

    // Controller FSM, step counter, gate-input and result registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            step      <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            FAIL_MAP  <= '0;
            FAIL_STEP <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        FAIL_MAP  <= '0;
                        FAIL_STEP <= '0;
                        PASS      <= 1'b0;
                        step      <= '0;
                        a_reg     <= a_nxt;
                        b_reg     <= b_nxt;
                        BUSY      <= 1'b1;
                        state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_expire) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    FAIL_MAP <= FAIL_MAP | mismatch;
                    if ((FAIL_MAP == '0) && (mismatch != '0)) begin
                        FAIL_STEP <= step;
                    end
                    if (last_step) begin
                        // PASS is set on entry to REPORT so it is valid while DONE is high.
                        PASS  <= ((FAIL_MAP | mismatch) == '0);
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= ST_REPORT;
                    end else begin
                        step  <= step + 2'd1;
                        a_reg <= a_nxt;
                        b_reg <= b_nxt;
                        state <= ST_SETTLE;
                    end
                end
                ST_REPORT: begin
                    DONE  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign A1 = a_reg[0];
    assign A2 = a_reg[1];
    assign A3 = a_reg[2];
    assign A4 = a_reg[3];
    assign B1 = b_reg[0];
    assign B2 = b_reg[1];
    assign B3 = b_reg[2];
    assign B4 = b_reg[3];

endmodule

// File: tb/tb_ttl_7400_bist.sv
// Directed bench for ttl_7400_bist with a behavioural TTL_7400 that can
// have individual outputs stuck at a fixed level.
module tb_ttl_7400_bist;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       y1, y2, y3, y4;
    logic       a1, b1, a2, b2, a3, b3, a4, b4;
    logic       busy, done, pass;
    logic [3:0] fail_map;
    logic [1:0] fail_step;
    logic [3:0] stuck_en = '0;
    logic [3:0] stuck_val = '0;

    int checks = 0;
    int errors = 0;

    // Hand-computed step vectors, gate 4 in the MSB.
    logic [3:0] exp_a [4] = '{4'b1010, 4'b0101, 4'b1010, 4'b0101};
    logic [3:0] exp_b [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};

    always #5 clk = ~clk;

    // Behavioural NAND package with optional stuck outputs.
    always_comb begin
        y1 = stuck_en[0] ? stuck_val[0] : ~(a1 & b1);
        y2 = stuck_en[1] ? stuck_val[1] : ~(a2 & b2);
        y3 = stuck_en[2] ? stuck_val[2] : ~(a3 & b3);
        y4 = stuck_en[3] ? stuck_val[3] : ~(a4 & b4);
    end

    ttl_7400_bist #(.SETTLE_CYCLES(4)) dut (
        .CLK       (clk),
        .RST       (rst),
        .START     (start),
        .Y1        (y1),
        .Y2        (y2),
        .Y3        (y3),
        .Y4        (y4),
        .A1        (a1),
        .B1        (b1),
        .A2        (a2),
        .B2        (b2),
        .A3        (a3),
        .B3        (b3),
        .A4        (a4),
        .B4        (b4),
        .BUSY      (busy),
        .DONE      (done),
        .PASS      (pass),
        .FAIL_MAP  (fail_map),
        .FAIL_STEP (fail_step)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_map"}, 32'(fail_map), 32'd0);
        check({tag, "_step"}, 32'(fail_step), 32'd0);
        check({tag, "_a"}, 32'({a4, a3, a2, a1}), 32'd0);
        check({tag, "_b"}, 32'({b4, b3, b2, b1}), 32'd0);
        check({tag, "_y"}, 32'({y4, y3, y2, y1}), 32'hF);
    endtask

    // One full run from a START pulse at edge 0 through the REPORT cycle.
    task automatic run_test(input string tag, input logic [3:0] en, input logic [3:0] val,
                            input logic [3:0] exp_map, input logic [1:0] exp_step,
                            input logic exp_pass, input bit extra);
        int busy_cnt = 0;
        int done_early = 0;
        stuck_en  = en;
        stuck_val = val;
        start = 1'b1;
        tick();
        for (int e = 0; e <= 20; e++) begin
            if (e > 0) tick();
            start = extra && ((e == 4) || (e == 11));
            if (busy) busy_cnt++;
            if (done && (e != 20)) done_early++;
            if ((e % 5 == 0) && (e < 20)) begin
                check({tag, "_vec_a"}, 32'({a4, a3, a2, a1}), 32'(exp_a[e / 5]));
                check({tag, "_vec_b"}, 32'({b4, b3, b2, b1}), 32'(exp_b[e / 5]));
            end
        end
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd20);
        check({tag, "_done_early"}, 32'(done_early), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'(exp_pass));
        check({tag, "_map"}, 32'(fail_map), 32'(exp_map));
        check({tag, "_step"}, 32'(fail_step), 32'(exp_step));
        tick();
        check({tag, "_done_off"}, 32'(done), 32'd0);
        check({tag, "_pass_hold"}, 32'(pass), 32'(exp_pass));
        check({tag, "_vec_hold"}, 32'({b4, b3, b2, b1, a4, a3, a2, a1}), 32'({exp_b[3], exp_a[3]}));
        stuck_en = '0;
    endtask

    initial begin
        int done_cnt;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        run_test("good", 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
        run_test("y3_sa1", 4'b0100, 4'b0100, 4'b0100, 2'd1, 1'b0, 1'b0);
        run_test("y12_sa0", 4'b0011, 4'b0000, 4'b0011, 2'd0, 1'b0, 1'b0);
        run_test("extra_start", 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1);

        // START held high: first run has Y3 stuck, later runs a good chip
        stuck_en  = 4'b0100;
        stuck_val = 4'b0100;
        done_cnt  = 0;
        start = 1'b1;
        tick();
        for (int e = 1; e <= 64; e++) begin
            tick();
            if (done) done_cnt++;
            if (e == 20) begin
                check("held_done1", 32'(done), 32'd1);
                check("held_map1", 32'(fail_map), 32'h4);
            end
            if (e == 21) stuck_en = '0;
            if (e == 22) begin
                check("held_map_clr", 32'(fail_map), 32'd0);
                check("held_busy2", 32'(busy), 32'd1);
                check("held_pass_clr", 32'(pass), 32'd0);
            end
            if (e == 42) begin
                check("held_done2", 32'(done), 32'd1);
                check("held_pass2", 32'(pass), 32'd1);
            end
            if (e == 64) begin
                check("held_done3", 32'(done), 32'd1);
                start = 1'b0;
            end
        end
        check("held_done_count", 32'(done_cnt), 32'd3);
        tick();
        tick();
        check("held_idle_busy", 32'(busy), 32'd0);

        // Reset mid-run at edge 10
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 9; e++) tick();
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        done_cnt = 0;
        for (int e = 0; e < 25; e++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        run_test("after_rst", 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ttl_7400_bist.md
# ttl_7400_bist

Built-in self-test controller for one TTL_7400 quad 2-input NAND package. On START it drives every gate through all four input combinations, waits a programmable settle time after each vector, and compares every Y against the expected NAND result. It reports pass/fail, a per-gate failure map and the first failing step. It sits beside the TTL_7400 instance and owns all eight gate inputs while a test is running.

## Interface
- SETTLE_CYCLES, 4: number of cycles between driving a vector and sampling Y. Legal range 1..255.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  begin a test. Sampled only in IDLE.
- Y1, Y2, Y3, Y4  in  1 each  gate outputs from the TTL_7400.
- A1, B1, A2, B2, A3, B3, A4, B4  out  1 each  registered gate inputs.
- BUSY  out  1  high from the START-sampling edge until REPORT is entered.
- DONE  out  1  one-cycle pulse while in REPORT.
- PASS  out  1  1 when the last test had no mismatch. Valid from REPORT until the next START.
- FAIL_MAP  out  4  bit k is sticky-set if gate k+1 mismatched on any step.
- FAIL_STEP  out  2  step index v of the first mismatch. 0 when FAIL_MAP == 0.

## Operation
- States: IDLE, SETTLE, SAMPLE, REPORT.
- Vector rule: at step v (0..3), gate k (0..3, i.e. gates 1..4) receives u = (v+k) mod 4, with A = u[0] and B = u[1]. Expected Y = ~(A & B). Rotating u makes adjacent gates see different inputs, which exposes inter-gate shorts.
- IDLE with START = 1:
  - clear FAIL_MAP, FAIL_STEP and PASS;
  - v ← 0; drive the step-0 vectors;
  - cnt ← SETTLE_CYCLES; BUSY ← 1; go to SETTLE.
- SETTLE: cnt decrements each cycle. When cnt == 1, go to SAMPLE.
- SAMPLE: compare Y1..Y4 against expected.
  - OR mismatches into FAIL_MAP.
  - If FAIL_MAP was 0 before this sample and any mismatch occurs, FAIL_STEP ← v.
  - If v == 3, go to REPORT. Otherwise v ← v+1, drive the new vectors, reload cnt, go to SETTLE.
- REPORT: DONE = 1, BUSY = 0, PASS = (FAIL_MAP == 0), then go to IDLE.
- START outside IDLE is ignored. START held high restarts from IDLE on the following cycle.
- RST (any state, including mid-test):
  - state IDLE;
  - all A/B = 0, BUSY = 0, DONE = 0, PASS = 0, FAIL_MAP = 0, FAIL_STEP = 0;
  - v = 0, cnt = 0;
  - no DONE pulse for an aborted run.
- Gate inputs hold their last vector after REPORT until the next START or RST.

## Timing
- Edge 0 is the edge that samples START.
- Step v vectors change at edge v·(SETTLE_CYCLES+1).
- Y is sampled at edge v·(SETTLE_CYCLES+1)+SETTLE_CYCLES+1, i.e. Y must be stable SETTLE_CYCLES cycles after the drive.
- REPORT (DONE high) is the cycle after edge 4·(SETTLE_CYCLES+1). With the default, that is 20 edges.
- BUSY is high for exactly 4·(SETTLE_CYCLES+1) cycles.
- Back-to-back period with START held high: 4·(SETTLE_CYCLES+1)+2 edges.
- All outputs are registered; there is no combinational path from Y or START to any output.

## Structure
- Package ttl_bist_pkg:
  - state enum;
  - NUM_GATES = 4, NUM_STEPS = 4;
  - function vec(v, k) returning {B, A};
  - function nand_exp(a, b).
- Sub-module bist_settle_timer: 8-bit loadable down-counter with load, value and expire (cnt == 1) outputs.
- Controller FSM, step counter and result registers live in ttl_7400_bist.

## Test plan
- **Reset:** hold RST for 2 cycles with the bench's TTL_7400 connected -> all outputs 0, Y1..Y4 = 1.
- **Good chip, SETTLE_CYCLES = 4:** 1-cycle START pulse -> BUSY = 1 after edge 0, single DONE pulse after edge 20, PASS = 1, FAIL_MAP = 4'b0000, FAIL_STEP = 0.
- **Y3 forced stuck-at-1:**
  - Y3 fails only at u = 3, i.e. step v = 1.
  - Expect FAIL_MAP = 4'b0100, FAIL_STEP = 1, PASS = 0, DONE after edge 20.
- **Y1 and Y2 forced stuck-at-0:**
  - Both fail at step 0.
  - Expect FAIL_MAP = 4'b0011, FAIL_STEP = 0, PASS = 0.
- **START handling:**
  - Extra START pulses at edges 5 and 12 -> ignored, single DONE at edge 20.
  - START held high -> DONE pulses every 22 edges; FAIL_MAP cleared at each restart.
- **Reset mid-run:** RST at edge 10 -> next cycle all outputs 0 and no DONE; a following START completes a clean run with PASS = 1.
